// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised VGA timing and test-pattern generator
//
// Purpose: derives a pixel strobe from the system clock, generates HS/VS/BLANK
// timing from generic parameters and drives one of five test patterns. The
// pattern select is sampled only at pixel (0,0), so frames never tear.
//
// Optional feature macro: VGA_PATTERN_SCROLL_EN
//   defined   - checkerboard and horizontal ramp scroll left 1 pixel/frame
//   undefined - patterns depend on pixel coordinates only
//
// Ports:
//   Clk_50MHz    in   system clock
//   Reset        in   asynchronous active-high reset
//   Sw           in   one-hot pattern select, highest set bit wins
//   Red/Green/Blue out colour channels, COLOR_W bits each
//   VGA_CLK      out  pixel clock to DAC (rises mid-pixel)
//   VGA_BLANK_N  out  high during active video
//   VGA_HS       out  horizontal sync
//   VGA_VS       out  vertical sync
//   VGA_SYNC_N   out  tied low
//   Frame_Start  out  one-clock pulse when pixel (0,0) is output
//   Frame_Cnt    out  frames since reset, wrapping

module vga_pattern_gen #(
   parameter int CLK_DIV    = 2,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit SYNC_POL   = 1'b0,
   parameter int COLOR_W    = 8,
   parameter int NUM_MODES  = 5,
   parameter int CHECK_LOG2 = 5,
   parameter int GRAD_SHIFT = 2
) (
   input  logic                 Clk_50MHz,
   input  logic                 Reset,
   input  logic [NUM_MODES-1:0] Sw,
   output logic [COLOR_W-1:0]   Red,
   output logic [COLOR_W-1:0]   Green,
   output logic [COLOR_W-1:0]   Blue,
   output logic                 VGA_CLK,
   output logic                 VGA_BLANK_N,
   output logic                 VGA_HS,
   output logic                 VGA_VS,
   output logic                 VGA_SYNC_N,
   output logic                 Frame_Start,
   output logic [15:0]          Frame_Cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_L   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] BAR_W_L   = HW'(BAR_W);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_L   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [2:0] {
      MODE_BLACK = 3'd0,
      MODE_WHITE = 3'd1,
      MODE_VRAMP = 3'd2,
      MODE_HRAMP = 3'd3,
      MODE_CHECK = 3'd4,
      MODE_BARS  = 3'd5
   } mode_t;

   logic [DW-1:0]      div;
   logic [DW-1:0]      div_nxt;
   logic               pix_en;
   logic [HW-1:0]      h_cnt;
   logic [VW-1:0]      v_cnt;
   logic               h_wrap;
   logic               at_origin;
   mode_t              mode_r;
   mode_t              sw_mode;
   mode_t              mode_cur;
   logic [HW-1:0]      x_eff;
   logic [HW-1:0]      bar_q;
   logic [2:0]         bar;
   logic               active;
   logic               hs_pulse;
   logic               vs_pulse;
   logic [COLOR_W-1:0] r_pat;
   logic [COLOR_W-1:0] g_pat;
   logic [COLOR_W-1:0] b_pat;

   assign pix_en     = (div == DIV_LAST);
   assign div_nxt    = pix_en ? '0 : div + 1'b1;
   assign h_wrap     = (h_cnt == H_LAST);
   assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
   assign VGA_SYNC_N = 1'b0;

   // Priority encoder: later (higher) set bits override lower ones.
   always_comb begin
      sw_mode = MODE_BLACK;
      for (int i = 0; i < NUM_MODES && i < 5; i++) begin
         if (Sw[i]) sw_mode = mode_t'(3'(i + 1));
      end
   end

   // At the origin the mode and frame count being latched this cycle already
   // apply to pixel (0,0), so the whole frame uses one consistent setting.
   assign mode_cur = at_origin ? sw_mode : mode_r;

`ifdef VGA_PATTERN_SCROLL_EN
   logic [15:0] fc_cur;
   assign fc_cur = at_origin ? Frame_Cnt + 16'd1 : Frame_Cnt;
   assign x_eff  = h_cnt + HW'(fc_cur);
`else
   assign x_eff  = h_cnt;
`endif

   // Bar index, with remainder pixels beyond the eighth bar clamped to it.
   assign bar_q = h_cnt / BAR_W_L;
   assign bar   = (bar_q > HW'(7)) ? 3'd7 : bar_q[2:0];

   assign active   = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
   assign hs_pulse = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
   assign vs_pulse = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);

   always_comb begin
      r_pat = '0;
      g_pat = '0;
      b_pat = '0;
      unique case (mode_cur)
         // Bar order white..black maps to RGB = ~bar[1], ~bar[2], ~bar[0].
         MODE_BARS: begin
            r_pat = {COLOR_W{~bar[1]}};
            g_pat = {COLOR_W{~bar[2]}};
            b_pat = {COLOR_W{~bar[0]}};
         end
         MODE_CHECK: begin
            r_pat = {COLOR_W{x_eff[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]}};
            g_pat = r_pat;
            b_pat = r_pat;
         end
         MODE_HRAMP: begin
            r_pat = COLOR_W'(x_eff >> GRAD_SHIFT);
            g_pat = r_pat;
            b_pat = r_pat;
         end
         MODE_VRAMP: begin
            g_pat = COLOR_W'(v_cnt >> GRAD_SHIFT);
         end
         MODE_WHITE: begin
            r_pat = '1;
            g_pat = '1;
            b_pat = '1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk_50MHz or posedge Reset) begin
      if (Reset) begin
         div         <= '0;
         VGA_CLK     <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         mode_r      <= MODE_BLACK;
         Frame_Cnt   <= '0;
         Frame_Start <= 1'b0;
         Red         <= '0;
         Green       <= '0;
         Blue        <= '0;
         VGA_BLANK_N <= 1'b0;
         VGA_HS      <= ~SYNC_POL;
         VGA_VS      <= ~SYNC_POL;
      end else begin
         div         <= div_nxt;
         // Low for the first half of the pixel, so it rises mid-pixel.
         VGA_CLK     <= (div_nxt >= DIV_HALF);
         Frame_Start <= pix_en && at_origin;
         if (pix_en) begin
            if (h_wrap) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
            if (at_origin) begin
               mode_r    <= sw_mode;
               Frame_Cnt <= Frame_Cnt + 16'd1;
            end
            VGA_BLANK_N <= active;
            VGA_HS      <= hs_pulse ? SYNC_POL : ~SYNC_POL;
            VGA_VS      <= vs_pulse ? SYNC_POL : ~SYNC_POL;
            Red         <= active ? r_pat : '0;
            Green       <= active ? g_pat : '0;
            Blue        <= active ? b_pat : '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard testbench for vga_pattern_gen
`timescale 1ns/1ps

module tb_vga_pattern_gen;

   localparam int H_TOT     = 84;
   localparam int V_TOT     = 17;
   localparam int CDIV      = 4;
   localparam int LINE_CLK  = H_TOT * CDIV;
   localparam int FRAME_CLK = LINE_CLK * V_TOT;

   logic        clk = 1'b0;
   logic        Reset;
   logic [4:0]  Sw;
   logic [3:0]  Red, Green, Blue;
   logic        VGA_CLK, VGA_BLANK_N, VGA_HS, VGA_VS, VGA_SYNC_N, Frame_Start;
   logic [15:0] Frame_Cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         frame;
      int         x;
      int         y;
      logic [11:0] rgb;
      logic [2:0]  ctl;
   } exp_t;

   exp_t sb[$];

   vga_pattern_gen #(
      .CLK_DIV(CDIV), .H_ACTIVE(68), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0),
      .COLOR_W(4), .NUM_MODES(5), .CHECK_LOG2(2), .GRAD_SHIFT(1)
   ) dut (
      .Clk_50MHz(clk), .Reset(Reset), .Sw(Sw),
      .Red(Red), .Green(Green), .Blue(Blue),
      .VGA_CLK(VGA_CLK), .VGA_BLANK_N(VGA_BLANK_N), .VGA_HS(VGA_HS),
      .VGA_VS(VGA_VS), .VGA_SYNC_N(VGA_SYNC_N),
      .Frame_Start(Frame_Start), .Frame_Cnt(Frame_Cnt)
   );

   always #10 clk = ~clk;

   // ctl = {BLANK_N, HS, VS}
   task automatic push(input int f, input int x, input int y,
                       input logic [11:0] rgb, input logic [2:0] ctl);
      exp_t e;
      e.frame = f; e.x = x; e.y = y; e.rgb = rgb; e.ctl = ctl;
      sb.push_back(e);
   endtask

   task automatic check_reset(input string name);
      logic [31:0] act;
      act = {Red, Green, Blue, VGA_BLANK_N, VGA_HS, VGA_VS, VGA_CLK,
             VGA_SYNC_N, Frame_Start, Frame_Cnt};
      n_cmp++;
      if (act !== {12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act,
                  {12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      end
   endtask

   task automatic wait_fs();
      bit got;
      got = 1'b0;
      for (int c = 0; c < FRAME_CLK + 100 && !got; c++) begin
         @(posedge clk); #1;
         if (Frame_Start) got = 1'b1;
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL frame_start_timeout: got none want pulse");
      end
   endtask

   task automatic check_first_fs(input string name);
      int  cyc;
      bit  got;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (Frame_Start) got = 1'b1;
      end
      n_cmp++;
      if (!got || cyc != CDIV || Frame_Cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL %s: got clocks=%0d cnt=%0d want clocks=%0d cnt=1",
                  name, cyc, Frame_Cnt, CDIV);
      end
   endtask

   // Monitor: each VGA_CLK rise presents one pixel; coordinates restart at
   // every Frame_Start and are tracked independently of the DUT counters.
   initial begin : monitor
      int   mframe;
      int   mx;
      int   my;
      logic prev;
      bit   run;
      exp_t e;
      mframe = 0; mx = 0; my = 0; prev = 1'b0; run = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (Reset) begin
            run = 1'b0; mframe = 0; prev = VGA_CLK;
         end else begin
            if (Frame_Start) begin
               run = 1'b1; mframe++; mx = 0; my = 0;
               n_cmp++;
               if (Frame_Cnt !== 16'(mframe)) begin
                  n_bad++;
                  $display("FAIL frame_cnt: got %0d want %0d", Frame_Cnt, mframe);
               end
            end
            if (run && VGA_CLK && !prev) begin
               if (sb.size() > 0 && sb[0].frame == mframe && sb[0].x == mx && sb[0].y == my) begin
                  e = sb.pop_front();
                  n_cmp++;
                  if ({Red, Green, Blue} !== e.rgb ||
                      {VGA_BLANK_N, VGA_HS, VGA_VS} !== e.ctl) begin
                     n_bad++;
                     $display("FAIL pixel f%0d (%0d,%0d): got rgb=%h ctl=%b want rgb=%h ctl=%b",
                              mframe, mx, my, {Red, Green, Blue},
                              {VGA_BLANK_N, VGA_HS, VGA_VS}, e.rgb, e.ctl);
                  end
               end
               mx++;
               if (mx == H_TOT) begin
                  mx = 0; my++;
                  if (my == V_TOT) my = 0;
               end
            end
            prev = VGA_CLK;
         end
      end
   end

   initial begin : stim
      logic [4:0] next_sw [4];
      next_sw[0] = 5'b01000; next_sw[1] = 5'b00110;
      next_sw[2] = 5'b00010; next_sw[3] = 5'b00000;
      Reset = 1'b1;
      Sw    = 5'b10000;

      // frame 1: colour bars, select changes mid-frame
      push(1, 0, 0, 12'hFFF, 3'b111);  push(1, 7, 0, 12'hFFF, 3'b111);
      push(1, 8, 0, 12'hFF0, 3'b111);  push(1, 63, 0, 12'h000, 3'b111);
      push(1, 65, 0, 12'h000, 3'b111); push(1, 71, 2, 12'h000, 3'b011);
      push(1, 72, 2, 12'h000, 3'b001); push(1, 79, 2, 12'h000, 3'b001);
      push(1, 80, 2, 12'h000, 3'b011); push(1, 16, 3, 12'h0FF, 3'b111);
      push(1, 24, 3, 12'h0F0, 3'b111); push(1, 32, 5, 12'hF0F, 3'b111);
      push(1, 40, 5, 12'hF00, 3'b111); push(1, 48, 5, 12'h00F, 3'b111);
      push(1, 56, 5, 12'h000, 3'b111); push(1, 8, 8, 12'hFF0, 3'b111);
      push(1, 65, 8, 12'h000, 3'b111);
      // frame 2: checkerboard (4-pixel squares) and vertical sync
      push(2, 0, 0, 12'h000, 3'b111);  push(2, 4, 0, 12'hFFF, 3'b111);
      push(2, 65, 0, 12'h000, 3'b111); push(2, 0, 4, 12'hFFF, 3'b111);
      push(2, 4, 4, 12'h000, 3'b111);  push(2, 0, 12, 12'h000, 3'b011);
      push(2, 0, 13, 12'h000, 3'b010); push(2, 72, 13, 12'h000, 3'b000);
      push(2, 83, 14, 12'h000, 3'b010); push(2, 0, 15, 12'h000, 3'b011);
      // frame 3: horizontal ramp wins over vertical ramp
      push(3, 2, 0, 12'h111, 3'b111);  push(3, 31, 0, 12'hFFF, 3'b111);
      push(3, 32, 0, 12'h000, 3'b111); push(3, 67, 0, 12'h111, 3'b111);
      push(3, 68, 0, 12'h000, 3'b011);
      // frame 4: vertical ramp on green only
      push(4, 0, 0, 12'h000, 3'b111);  push(4, 0, 3, 12'h010, 3'b111);
      push(4, 5, 7, 12'h030, 3'b111);  push(4, 10, 11, 12'h050, 3'b111);
      // frame 5: no select bits -> black, sync still running
      push(5, 0, 0, 12'h000, 3'b111);  push(5, 40, 3, 12'h000, 3'b111);
      push(5, 72, 4, 12'h000, 3'b001); push(5, 30, 6, 12'h000, 3'b111);

      repeat (5) @(posedge clk);
      #1;
      check_reset("reset_init");
      @(negedge clk);
      Reset = 1'b0;
      check_first_fs("first_fs_latency");

      for (int k = 0; k < 4; k++) begin
         if (k > 0) wait_fs();
         repeat (6 * LINE_CLK) @(posedge clk);
         Sw = next_sw[k];
      end

      wait_fs();
      repeat (8 * LINE_CLK) @(posedge clk);
      #5;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain_pre_reset: got %0d pending want 0", sb.size());
      end
      Reset = 1'b1;
      #1;
      check_reset("reset_mid_frame");
      Sw = 5'b00001;
      push(1, 0, 0, 12'hFFF, 3'b111);   push(1, 68, 0, 12'h000, 3'b011);
      push(1, 67, 11, 12'hFFF, 3'b111); push(1, 0, 12, 12'h000, 3'b011);
      push(1, 72, 13, 12'h000, 3'b000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
      check_first_fs("post_reset_fs");

      for (int c = 0; c < FRAME_CLK && sb.size() != 0; c++) @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain_final: got %0d pending want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
